// File: rtl/scrambler_pkg.sv
// scrambler_pkg
// Shared types for the 257-bit transmit scrambler sequencer: the block
// type, the sequencer FSM states and a width helper for index/counter
// ports that must stay at least one bit wide.
package scrambler_pkg;

    localparam int BLK_W = 257;

    typedef logic [BLK_W-1:0] blk_t;

    typedef enum logic [1:0] {
        IDLE,
        AM,
        RUN
    } scr_ctrl_state_t;

    // $clog2 with a floor of one bit, so depth-1 tables still get a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scrambler_ctrl.sv
// scrambler_ctrl
// Sequencer for the 257-bit block scrambler in the AUI transmit path.
// Accepts transcoded blocks, gates the external scrambler's state advance,
// and every AM_PERIOD data blocks inserts AM_LEN raw alignment-marker
// blocks while the scrambler is frozen. Markers and scrambled data are
// merged into one stream with equal one-cycle latency, so order is kept.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   en                level enable; stream always starts with a marker group
//   s_data/s_valid/s_ready   upstream block handshake
//   am_data / am_idx  external AM table lookup (combinational)
//   scr_en / scr_data scrambler advance enable and input
//   scr_q             scrambler registered output (1 cycle after scr_en)
//   m_data / m_valid  merged output stream, no backpressure
//   am_start          pulse with the first marker of each group
//   blk_cnt           data blocks accepted since the last group
module scrambler_ctrl
    import scrambler_pkg::*;
#(
    parameter  int AM_PERIOD = 16384,
    parameter  int AM_LEN    = 4,
    localparam int IDX_W     = idx_w(AM_LEN),
    localparam int CNT_W     = idx_w(AM_PERIOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  blk_t             s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  blk_t             am_data,
    output logic [IDX_W-1:0] am_idx,
    output logic             scr_en,
    output blk_t             scr_data,
    input  blk_t             scr_q,
    output blk_t             m_data,
    output logic             m_valid,
    output logic             am_start,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam logic [IDX_W-1:0] AM_LAST  = IDX_W'(AM_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 1);

    scr_ctrl_state_t  state, state_d;
    logic [IDX_W-1:0] am_idx_d;
    logic [CNT_W-1:0] blk_cnt_d;

    logic accept;
    logic am_issue;

    // Output stage registers
    logic sel_am_q;
    blk_t am_q;
    logic valid_q;
    logic am_start_q;

    // Upstream is only taken in RUN; a block taken in the same cycle en
    // drops is still scrambled and emitted.
    assign s_ready  = (state == RUN);
    assign accept   = s_ready & s_valid;
    assign am_issue = (state == AM);
    assign scr_en   = accept;
    assign scr_data = s_data;

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            am_idx  <= '0;
            blk_cnt <= '0;
        end else begin
            state   <= state_d;
            am_idx  <= am_idx_d;
            blk_cnt <= blk_cnt_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM next state
    // blk_cnt holds at AM_PERIOD-1 through a group and clears only when
    // the group completes, so it never exceeds AM_PERIOD-1.
    // ---------------------------------------------------------------
    always_comb begin
        state_d   = state;
        am_idx_d  = am_idx;
        blk_cnt_d = blk_cnt;
        case (state)
            IDLE: begin
                if (en) begin
                    state_d  = AM;
                    am_idx_d = '0;
                end
            end
            AM: begin
                // A group always runs to completion regardless of en.
                if (am_idx == AM_LAST) begin
                    am_idx_d  = '0;
                    blk_cnt_d = '0;
                    state_d   = en ? RUN : IDLE;
                end else begin
                    am_idx_d = am_idx + IDX_W'(1);
                end
            end
            RUN: begin
                if (!en) begin
                    state_d   = IDLE;
                    blk_cnt_d = '0;
                end else if (s_valid) begin
                    if (blk_cnt == CNT_LAST) begin
                        state_d  = AM;
                        am_idx_d = '0;
                    end else begin
                        blk_cnt_d = blk_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                am_idx_d  = '0;
                blk_cnt_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output stage: one register stage on the marker path lines it up
    // with the scrambler's own one-cycle latency on the data path.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_am_q   <= 1'b0;
            am_q       <= '0;
            valid_q    <= 1'b0;
            am_start_q <= 1'b0;
        end else begin
            sel_am_q   <= am_issue;
            valid_q    <= am_issue | accept;
            am_start_q <= am_issue & (am_idx == '0);
            if (am_issue) begin
                am_q <= am_data;
            end
        end
    end

    assign m_data   = sel_am_q ? am_q : scr_q;
    assign m_valid  = valid_q;
    assign am_start = am_start_q;

endmodule

// File: doc/scrambler_ctrl.md
# scrambler_ctrl

Sequencer for the 257-bit block scrambler in the 1.6T AUI transmit path. It accepts transcoded 257-bit blocks from upstream and gates the scrambler's state advance. Every AM_PERIOD data blocks it inserts a group of AM_LEN unscrambled alignment-marker blocks, during which the scrambler state is frozen. It muxes scrambled data and markers into one output stream.

## Interface
- AM_PERIOD, 16384: data blocks between alignment-marker groups (≥2).
- AM_LEN, 4: marker blocks per group (≥1).
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  level enable; starts/stops the stream.
- s_data  in  257  upstream transcoded block.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block accepted when s_valid & s_ready.
- am_data  in  257  marker block for current am_idx, supplied combinationally by the AM table.
- am_idx  out  $clog2(AM_LEN) (min 1)  index of marker being inserted.
- scr_en  out  1  scrambler state-advance enable; scrambler registers scr_data only when high.
- scr_data  out  257  scrambler input (= s_data).
- scr_q  in  257  scrambler registered output, 1-cycle latency from scr_en.
- m_data  out  257  output block (scrambled data or raw marker).
- m_valid  out  1  m_data valid.
- am_start  out  1  one-cycle pulse, coincident with m_valid of first marker of each group.
- blk_cnt  out  $clog2(AM_PERIOD)  data blocks accepted since last group.

## Operation
- FSM states: IDLE, AM, RUN.
- IDLE: s_ready=0, scr_en=0. en=1 → AM with am_idx=0. Stream always begins with a marker group.
- AM:
  - s_ready=0, scr_en=0.
  - Each cycle emits am_data[am_idx] and increments am_idx.
  - After am_idx=AM_LEN-1: blk_cnt←0, then → RUN if en=1, else → IDLE.
  - en dropping mid-group does not truncate the group.
- RUN:
  - s_ready=1; scr_en = s_valid; scr_data = s_data.
  - Each accepted block increments blk_cnt.
  - Accepting with blk_cnt=AM_PERIOD-1 → AM (am_idx=0).
  - Cycles without s_valid produce no output bubble-fill (m_valid=0) and do not advance the scrambler.
  - en=0 in RUN → IDLE next cycle, blk_cnt cleared. A block accepted in that same cycle is still processed.
- Output stage registers sel_am, the marker block and valid. m_data = sel_am_q ? am_q : scr_q. m_valid = valid_q.
- No downstream backpressure; the consumer must take a block every m_valid cycle.
- Scrambler state is never reseeded by this block; only scrambler reset reseeds.

## Timing
- Latency: input accept or marker issue at edge N → m_valid high in cycle N+1, for both paths, so order is preserved.
- Full throughput: one block per cycle. Per period: AM_LEN marker cycles plus AM_PERIOD data cycles at 100% s_valid.
- Reset values: state=IDLE, am_idx=0, blk_cnt=0, s_ready=0, scr_en=0, m_valid=0, am_start=0, internal m_data regs=0.
- Reset asserted mid-group or mid-run: everything returns to reset values immediately (async). Deassertion restarts from IDLE.
- blk_cnt wraps only via the group transition; it never exceeds AM_PERIOD-1.
- AM_LEN=1: group is a single cycle; am_idx stays 0.

## Structure
- Package scrambler_pkg:
  - localparam BLK_W=257.
  - typedef logic [BLK_W-1:0] blk_t.
  - typedef enum {IDLE, AM, RUN} scr_ctrl_state_t.
- Single module; no sub-module needed. The AM table is external, so the design can share it with the receive-side aligner.
- Bench instantiates scrambler_ctrl plus a scrambler model with an enable input.

## Test plan
Parameters for all scenarios: AM_PERIOD=4, AM_LEN=2.
1. Reset release, en=1, s_valid=1 continuously → m_valid pattern AM0,AM1,D0..D3,AM0,AM1,D4..; am_start pulses on each AM0. s_ready is low exactly on the 2 marker cycles.
2. Marker bypass → m_data during markers equals am_data bit-exact. Data blocks match a reference scrambler model that skips the marker cycles (LFSR continuity across groups).
3. s_valid toggling 1,0,1,0 in RUN → m_valid gaps mirror the input one cycle later; scrambler state advances only on accepted blocks; blk_cnt counts 0→3 over 8 cycles.
4. en dropped during AM1 → AM1 still emitted, then IDLE, s_ready=0, no further m_valid. en re-raised → new group starting AM0.
5. en dropped in RUN with blk_cnt=2 → the accepted block is emitted, then IDLE with blk_cnt=0. Restart begins with a marker group.
6. rst_n asserted while blk_cnt=3 and s_valid=1 → all outputs zero immediately, no m_valid on the following cycle; after release, behaves as scenario 1.
